// File: rtl/match_sequencer.sv
// Quidditch match scheduler: sequences idle/kickoff/play/goal/over, gates the
// ball controller, runs the match countdown and keeps saturating team scores.
module match_sequencer #(
  parameter int TICKS_PER_SEC  = 50_000_000,
  parameter int MATCH_SECONDS  = 180,
  parameter int KICKOFF_CYCLES = 25_000_000,
  parameter int GOAL_CYCLES    = 100_000_000,
  parameter int MAX_SCORE      = 99
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_req,
  input  logic       blue_goal_tgl,
  input  logic       red_goal_tgl,
  output logic       ball_enable,
  output logic       ball_reset,
  output logic [7:0] time_left,
  output logic [6:0] blue_score,
  output logic [6:0] red_score,
  output logic [2:0] phase,
  output logic       game_over
);

  localparam logic [2:0] PH_IDLE    = 3'd0;
  localparam logic [2:0] PH_KICKOFF = 3'd1;
  localparam logic [2:0] PH_PLAY    = 3'd2;
  localparam logic [2:0] PH_GOAL    = 3'd3;
  localparam logic [2:0] PH_OVER    = 3'd4;

  localparam int CYC_MAX = (KICKOFF_CYCLES > GOAL_CYCLES) ? KICKOFF_CYCLES : GOAL_CYCLES;
  localparam int CYC_W   = (CYC_MAX > 1) ? $clog2(CYC_MAX) : 1;
  localparam int SEC_W   = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;

  localparam logic [CYC_W-1:0] KICK_LAST  = CYC_W'(KICKOFF_CYCLES - 1);
  localparam logic [CYC_W-1:0] GOAL_LAST  = CYC_W'(GOAL_CYCLES - 1);
  localparam logic [SEC_W-1:0] SEC_LAST   = SEC_W'(TICKS_PER_SEC - 1);
  localparam logic [7:0]       TIME_INIT  = 8'(MATCH_SECONDS);
  localparam logic [6:0]       SCORE_MAX  = 7'(MAX_SCORE);

  logic             armed;
  logic             start_s, start_q, blue_s, blue_q, red_s, red_q;
  logic             start_rise, blue_ev, red_ev;
  logic [SEC_W-1:0] sec_cnt, sec_n;
  logic [CYC_W-1:0] cyc_cnt, cyc_n;
  logic [2:0]       phase_n;
  logic [7:0]       time_n;
  logic [6:0]       blue_n, red_n;

  // Inputs are sampled once, then compared with the previous sample; on the
  // first clock after reset both stages take the live level so no edge is faked.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed   <= 1'b0;
      start_s <= 1'b0;
      start_q <= 1'b0;
      blue_s  <= 1'b0;
      blue_q  <= 1'b0;
      red_s   <= 1'b0;
      red_q   <= 1'b0;
    end else begin
      armed   <= 1'b1;
      start_s <= start_req;
      blue_s  <= blue_goal_tgl;
      red_s   <= red_goal_tgl;
      start_q <= armed ? start_s : start_req;
      blue_q  <= armed ? blue_s  : blue_goal_tgl;
      red_q   <= armed ? red_s   : red_goal_tgl;
    end
  end

  assign start_rise = start_s & ~start_q;
  assign blue_ev    = blue_s ^ blue_q;
  assign red_ev     = red_s ^ red_q;

  always_comb begin
    phase_n = phase;
    time_n  = time_left;
    sec_n   = sec_cnt;
    cyc_n   = cyc_cnt;
    blue_n  = blue_score;
    red_n   = red_score;
    case (phase)
      PH_KICKOFF: begin
        if (cyc_cnt == KICK_LAST) begin
          phase_n = PH_PLAY;
          cyc_n   = '0;
        end else begin
          cyc_n = cyc_cnt + 1'b1;
        end
      end
      PH_PLAY: begin
        if (blue_ev && (blue_score < SCORE_MAX)) blue_n = blue_score + 7'd1;
        if (red_ev && (red_score < SCORE_MAX))   red_n  = red_score + 7'd1;
        if (blue_ev || red_ev) begin
          phase_n = PH_GOAL;
          cyc_n   = '0;
        end
        // The last second expiring overrides a simultaneous goal pause.
        if (sec_cnt == SEC_LAST) begin
          sec_n  = '0;
          time_n = time_left - 8'd1;
          if (time_left == 8'd1) phase_n = PH_OVER;
        end else begin
          sec_n = sec_cnt + 1'b1;
        end
      end
      PH_GOAL: begin
        if (cyc_cnt == GOAL_LAST) begin
          phase_n = PH_KICKOFF;
          cyc_n   = '0;
        end else begin
          cyc_n = cyc_cnt + 1'b1;
        end
      end
      PH_OVER: begin
        if (start_rise) begin
          phase_n = PH_KICKOFF;
          cyc_n   = '0;
          sec_n   = '0;
          time_n  = TIME_INIT;
          blue_n  = '0;
          red_n   = '0;
        end
      end
      default: begin
        phase_n = PH_IDLE;
        if (start_rise) begin
          phase_n = PH_KICKOFF;
          cyc_n   = '0;
        end
      end
    endcase
  end

  // Ball controls and game_over are registered from the next phase so they
  // line up with the phase output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase       <= PH_IDLE;
      time_left   <= TIME_INIT;
      sec_cnt     <= '0;
      cyc_cnt     <= '0;
      blue_score  <= '0;
      red_score   <= '0;
      ball_enable <= 1'b0;
      ball_reset  <= 1'b1;
      game_over   <= 1'b0;
    end else begin
      phase       <= phase_n;
      time_left   <= time_n;
      sec_cnt     <= sec_n;
      cyc_cnt     <= cyc_n;
      blue_score  <= blue_n;
      red_score   <= red_n;
      ball_enable <= (phase_n == PH_PLAY);
      ball_reset  <= (phase_n == PH_IDLE) || (phase_n == PH_KICKOFF);
      game_over   <= (phase_n == PH_OVER);
    end
  end

endmodule

// File: tb/tb_match_sequencer.sv
// Self-checking bench for match_sequencer: directed vector table, hand-written
// goal/restart/reset sequences, and randomized play against a reference model.
module tb_match_sequencer;

  localparam int TICKS = 4;
  localparam int MATCH = 3;
  localparam int KICK  = 2;
  localparam int GOALC = 3;
  localparam int MAXS  = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_req, blue_goal_tgl, red_goal_tgl;
  logic       ball_enable, ball_reset, game_over;
  logic [7:0] time_left;
  logic [6:0] blue_score, red_score;
  logic [2:0] phase;

  always #5 clk = ~clk;

  match_sequencer #(
    .TICKS_PER_SEC(TICKS), .MATCH_SECONDS(MATCH), .KICKOFF_CYCLES(KICK),
    .GOAL_CYCLES(GOALC), .MAX_SCORE(MAXS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start_req(start_req),
    .blue_goal_tgl(blue_goal_tgl), .red_goal_tgl(red_goal_tgl),
    .ball_enable(ball_enable), .ball_reset(ball_reset), .time_left(time_left),
    .blue_score(blue_score), .red_score(red_score), .phase(phase),
    .game_over(game_over)
  );

  typedef struct {
    logic st, bl, rd;
    int   ph, tl, bs, rs;
  } vec_t;

  int   total = 0;
  int   bad = 0;
  // Reference model: phase, cycles left in a pause, play cycles elapsed.
  int   m_phase, m_rem, m_played, m_blue, m_red, m_edges;
  logic p1s, p2s, p1b, p2b, p1r, p2r;
  logic st_lvl, bl_lvl, rd_lvl;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic modelReset();
    m_phase = 0; m_rem = 0; m_played = 0; m_blue = 0; m_red = 0; m_edges = 0;
    p1s = 0; p2s = 0; p1b = 0; p2b = 0; p1r = 0; p2r = 0;
  endtask

  // An input level seen at edge e is acted on at edge e+1, compared with e-1.
  task automatic modelStep(input logic s, input logic b, input logic r);
    bit rise, bev, rev;
    m_edges++;
    rise = (m_edges >= 3) && p1s && !p2s;
    bev  = (m_edges >= 3) && (p1b != p2b);
    rev  = (m_edges >= 3) && (p1r != p2r);
    case (m_phase)
      0: if (rise) begin m_phase = 1; m_rem = KICK; end
      1: begin m_rem--; if (m_rem == 0) m_phase = 2; end
      2: begin
        m_played++;
        if (bev && m_blue < MAXS) m_blue++;
        if (rev && m_red < MAXS) m_red++;
        if (m_played == MATCH * TICKS) m_phase = 4;
        else if (bev || rev) begin m_phase = 3; m_rem = GOALC; end
      end
      3: begin m_rem--; if (m_rem == 0) begin m_phase = 1; m_rem = KICK; end end
      default: if (rise) begin
        m_phase = 1; m_rem = KICK; m_blue = 0; m_red = 0; m_played = 0;
      end
    endcase
    p2s = p1s; p1s = s; p2b = p1b; p1b = b; p2r = p1r; p1r = r;
  endtask

  task automatic applyStimulus(input logic s, input logic b, input logic r);
    start_req = s; blue_goal_tgl = b; red_goal_tgl = r;
    @(posedge clk);
    modelStep(s, b, r);
    #1;
  endtask

  task automatic checkPhaseFlags(input string tag, input int ph);
    check({tag, "_enable"}, ball_enable, (ph == 2));
    check({tag, "_reset"}, ball_reset, (ph <= 1));
    check({tag, "_over"}, game_over, (ph == 4));
  endtask

  task automatic checkOutput();
    check("m_phase", phase, m_phase);
    check("m_time", time_left, MATCH - m_played / TICKS);
    check("m_blue", blue_score, m_blue);
    check("m_red", red_score, m_red);
    checkPhaseFlags("m", m_phase);
  endtask

  task automatic stepLevels();
    applyStimulus(st_lvl, bl_lvl, rd_lvl);
    checkOutput();
  endtask

  task automatic waitPhase(input int target);
    int n = 0;
    while (phase !== 3'(target) && n < 40) begin
      stepLevels();
      n++;
    end
    check("wait_phase", phase, target);
  endtask

  vec_t vecs[17];
  int   seq_ph[7];
  int   seq_bs[7];

  initial begin
    // Start pressed after the first clock, held five cycles, then a goalless match.
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 0, 3, 0, 0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 0, 3, 0, 0};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 1, 3, 0, 0};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 1, 3, 0, 0};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 2, 3, 0, 0};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 2, 3, 0, 0};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 2, 3, 0, 0};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 2, 3, 0, 0};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 2, 2, 0, 0};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 2, 2, 0, 0};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 2, 2, 0, 0};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 2, 2, 0, 0};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 2, 1, 0, 0};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 2, 1, 0, 0};
    vecs[14] = '{1'b0, 1'b0, 1'b0, 2, 1, 0, 0};
    vecs[15] = '{1'b0, 1'b0, 1'b0, 2, 1, 0, 0};
    vecs[16] = '{1'b0, 1'b0, 1'b0, 4, 0, 0, 0};
    seq_ph = '{2, 3, 3, 3, 1, 1, 2};
    seq_bs = '{0, 1, 1, 1, 1, 1, 1};

    rst_n = 1'b0; start_req = 1'b0; blue_goal_tgl = 1'b0; red_goal_tgl = 1'b0;
    st_lvl = 1'b0; bl_lvl = 1'b0; rd_lvl = 1'b0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_phase", phase, 0);
    check("rst_time", time_left, MATCH);
    check("rst_blue", blue_score, 0);
    check("rst_red", red_score, 0);
    checkPhaseFlags("rst", 0);
    rst_n = 1'b1;

    for (int i = 0; i < 17; i++) begin
      applyStimulus(vecs[i].st, vecs[i].bl, vecs[i].rd);
      check("vec_phase", phase, vecs[i].ph);
      check("vec_time", time_left, vecs[i].tl);
      check("vec_blue", blue_score, vecs[i].bs);
      check("vec_red", red_score, vecs[i].rs);
      checkPhaseFlags("vec", vecs[i].ph);
    end

    $display("[TB] restart from OVER");
    st_lvl = 1'b1;
    stepLevels();
    stepLevels();
    check("restart_phase", phase, 1);
    check("restart_time", time_left, MATCH);
    st_lvl = 1'b0;
    waitPhase(2);

    $display("[TB] blue goal, then ignored blue toggle during the pause");
    for (int k = 0; k < 7; k++) begin
      if (k == 0 || k == 2) bl_lvl = ~bl_lvl;
      stepLevels();
      check("goal_seq_phase", phase, seq_ph[k]);
      check("goal_seq_blue", blue_score, seq_bs[k]);
    end

    $display("[TB] simultaneous goals and saturation");
    bl_lvl = ~bl_lvl; rd_lvl = ~rd_lvl;
    stepLevels();
    stepLevels();
    check("both_blue", blue_score, 2);
    check("both_red", red_score, 1);
    check("both_phase", phase, 3);
    waitPhase(2);
    bl_lvl = ~bl_lvl;
    stepLevels();
    stepLevels();
    check("sat_blue", blue_score, 2);
    check("sat_phase", phase, 3);
    waitPhase(2);

    $display("[TB] goal on the final tick");
    for (int n = 0; n < 30 && m_phase == 2 && m_played < MATCH * TICKS - 2; n++) stepLevels();
    rd_lvl = ~rd_lvl;
    stepLevels();
    stepLevels();
    check("final_phase", phase, 4);
    check("final_red", red_score, 2);
    check("final_time", time_left, 0);
    check("final_over", game_over, 1);

    $display("[TB] restart, score, then reset mid-play");
    st_lvl = 1'b1;
    stepLevels();
    stepLevels();
    check("restart2_blue", blue_score, 0);
    check("restart2_red", red_score, 0);
    check("restart2_time", time_left, MATCH);
    st_lvl = 1'b0;
    waitPhase(2);
    bl_lvl = ~bl_lvl;
    stepLevels();
    stepLevels();
    waitPhase(2);
    #2 rst_n = 1'b0;
    #1;
    check("async_phase", phase, 0);
    check("async_reset", ball_reset, 1);
    check("async_enable", ball_enable, 0);
    check("async_blue", blue_score, 0);
    check("async_time", time_left, MATCH);
    #1 rst_n = 1'b1;
    modelReset();
    for (int n = 0; n < 4; n++) stepLevels();

    $display("[TB] randomized play");
    for (int n = 0; n < 2500; n++) begin
      if ($urandom_range(0, 5) == 0) st_lvl = ~st_lvl;
      if ($urandom_range(0, 4) == 0) bl_lvl = ~bl_lvl;
      if ($urandom_range(0, 4) == 0) rd_lvl = ~rd_lvl;
      stepLevels();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
